// File: rtl/ifetch_seq.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words from a byte ROM
// into a 2-entry queue for decode. Optional macro IFETCH_ALIGN_CHECK_EN traps misaligned redirects.
module ifetch_seq #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    output logic              align_fault
);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       word_pc_q, word_pc_d;
    logic [31:0]       inst0_q, inst0_d, inst1_q, inst1_d;
    logic [31:0]       pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]        count_q, count_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] addr_lo_s;
    logic [2:0]        occ_s;
    logic              room_s, halted_s, issue_s, pop_s, push_s;
    logic [31:0]       new_word_s;

    // Issue, capture, queue and redirect next-state logic
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        byte_cnt_d  = byte_cnt_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        asm_d       = asm_q;
        word_pc_d   = word_pc_q;
        inst0_d     = inst0_q;
        inst1_d     = inst1_q;
        pc0_d       = pc0_q;
        pc1_d       = pc1_q;
        count_d     = count_q;
        fault_d     = fault_q;

        addr_lo_s  = fetch_pc_q[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, byte_cnt_q};
        // A new word reserves a slot, counting a final byte still awaiting capture.
        occ_s      = {1'b0, count_q} + {2'b00, pend_last_q};
        if (byte_cnt_q == 2'd0) begin
            room_s = (occ_s < 3'd2);
        end else begin
            room_s = (count_q < 2'd2);
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        halted_s = fault_q;
`else
        halted_s = 1'b0;
`endif
        issue_s    = !rst && !redirect && !halted_s && room_s;
        pop_s      = (count_q != 2'd0) && inst_ready;
        push_s     = pend_q && pend_last_q;
        new_word_s = {asm_q[23:0], mem_rdata};

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            byte_cnt_d = 2'd0;
            count_d    = 2'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_d    = (redirect_pc[1:0] != 2'b00);
`else
            fault_d    = 1'b0;
`endif
        end else begin
            if (issue_s) begin
                byte_cnt_d  = byte_cnt_q + 2'd1;
                pend_d      = 1'b1;
                pend_last_d = (byte_cnt_q == 2'd3);
                if (byte_cnt_q == 2'd0) begin
                    word_pc_d = fetch_pc_q;
                end else begin
                    word_pc_d = word_pc_q;
                end
                if (byte_cnt_q == 2'd3) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
            end else begin
                byte_cnt_d = byte_cnt_q;
            end

            if (pend_q) begin
                asm_d = new_word_s;
            end else begin
                asm_d = asm_q;
            end

            case ({push_s, pop_s})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        inst0_d = new_word_s;
                        pc0_d   = word_pc_q;
                    end else begin
                        inst0_d = inst1_q;
                        pc0_d   = pc1_q;
                        inst1_d = new_word_s;
                        pc1_d   = word_pc_q;
                    end
                end
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        inst0_d = new_word_s;
                        pc0_d   = word_pc_q;
                    end else begin
                        inst1_d = new_word_s;
                        pc1_d   = word_pc_q;
                    end
                end
                2'b01: begin
                    count_d = count_q - 2'd1;
                    inst0_d = inst1_q;
                    pc0_d   = pc1_q;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            byte_cnt_q  <= 2'd0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            asm_q       <= 32'd0;
            word_pc_q   <= 32'd0;
            inst0_q     <= 32'd0;
            inst1_q     <= 32'd0;
            pc0_q       <= 32'd0;
            pc1_q       <= 32'd0;
            count_q     <= 2'd0;
            fault_q     <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            byte_cnt_q  <= byte_cnt_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            asm_q       <= asm_d;
            word_pc_q   <= word_pc_d;
            inst0_q     <= inst0_d;
            inst1_q     <= inst1_d;
            pc0_q       <= pc0_d;
            pc1_q       <= pc1_d;
            count_q     <= count_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_rd      = issue_s;
    assign mem_addr    = rst ? {ADDR_W{1'b0}} : addr_lo_s;
    assign inst_valid  = (count_q != 2'd0);
    assign inst        = inst0_q;
    assign inst_pc     = pc0_q;
    assign align_fault = fault_q;

endmodule
